imem_dmem_arbiter: RTL and testbench

- Sequences one shared single-port SRAM between two requesters:
  - the instruction-fetch port, driven by the fetch stage;
  - the data port, driven by the memory stage.
- Runs a multi-cycle SRAM access FSM and arbitrates round-robin.
- Returns a ready pulse per completed access.
- Derives the fetch-freeze and pipeline-stall signals that hold the fetch PC and the pipeline registers.

---
 rtl/imem_dmem_arbiter_if.sv | 34 +++
 rtl/imem_dmem_arbiter.sv | 93 +++++++++
 tb/tb_imem_dmem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if: fetch, data and SRAM signals of the shared-memory arbiter
interface imem_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          freeze_if;
  logic          stall_pipe;
  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we, sram_addr, sram_wdata,
           freeze_if, stall_pipe
  );
  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, sram_en, sram_we, sram_addr, sram_wdata,
           freeze_if, stall_pipe
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: round-robin sharing of one single-port SRAM between fetch and data ports
module imem_dmem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst,
  imem_dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  state_t state, state_nx;
  logic src, src_nx, we, we_nx, kill, kill_nx, last, last_nx;
  logic gnt_mem, go, kill_now, acc;
  logic [3:0] cnt, cnt_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [DW-1:0] wdata, wdata_nx, if_rd, if_rd_nx, mem_rd, mem_rd_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      src <= 1'b0;
      we <= 1'b0;
      kill <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      if_rd <= '0;
      mem_rd <= '0;
    end else begin
      state <= state_nx;
      src <= src_nx;
      we <= we_nx;
      kill <= kill_nx;
      last <= last_nx;
      cnt <= cnt_nx;
      addr <= addr_nx;
      wdata <= wdata_nx;
      if_rd <= if_rd_nx;
      mem_rd <= mem_rd_nx;
    end
  // src/last: 1 = data port, 0 = fetch port; a flush seen this cycle counts as a kill already
  always_comb begin
    gnt_mem = bus.mem_req & (~bus.if_req | ~last);
    go = gnt_mem | (bus.if_req & ~bus.if_flush);
    kill_now = kill | (bus.if_flush & ~src);
    state_nx = state;
    src_nx = src;
    we_nx = we;
    kill_nx = kill;
    last_nx = last;
    cnt_nx = cnt;
    addr_nx = addr;
    wdata_nx = wdata;
    if_rd_nx = if_rd;
    mem_rd_nx = mem_rd;
    if (state == IDLE && go) begin
      state_nx = ACC;
      src_nx = gnt_mem;
      last_nx = gnt_mem;
      we_nx = gnt_mem & bus.mem_we;
      addr_nx = gnt_mem ? bus.mem_addr : bus.if_addr;
      wdata_nx = gnt_mem ? bus.mem_wdata : '0;
      cnt_nx = 4'(WAIT_CYCLES - 1);
      kill_nx = 1'b0;
    end
    if (state == ACC) begin
      kill_nx = kill_now;
      cnt_nx = cnt - 4'd1;
      if (cnt == 4'd0) begin
        state_nx = RESP;
        cnt_nx = 4'd0;
        if_rd_nx = (~src & ~kill_now) ? bus.sram_rdata : if_rd;
        mem_rd_nx = (src & ~we) ? bus.sram_rdata : mem_rd;
      end
    end
    if (state == RESP) begin
      state_nx = IDLE;
      kill_nx = 1'b0;
    end
  end
  assign acc = state == ACC;
  assign bus.sram_en = acc;
  assign bus.sram_we = acc & src & we;
  assign bus.sram_addr = acc ? addr : '0;
  assign bus.sram_wdata = acc ? wdata : '0;
  assign bus.if_ready = (state == RESP) & ~src & ~kill_now;
  assign bus.mem_ready = (state == RESP) & src;
  assign bus.if_rdata = if_rd;
  assign bus.mem_rdata = mem_rd;
  assign bus.freeze_if = bus.if_req & ~bus.if_ready;
  assign bus.stall_pipe = bus.mem_req & ~bus.mem_ready;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: cycle-by-cycle vector table plus reset and WAIT_CYCLES=1 sequences
module tb_imem_dmem_arbiter;
  localparam logic [31:0] E = 32'hE3A00001, D = 32'hDEADBEEF;
  localparam logic [31:0] A1 = 32'h11111111, A2 = 32'h22222222, A3 = 32'h33333333;
  typedef struct packed {
    logic ir; logic [31:0] ia; logic fl;
    logic mr; logic mw; logic [31:0] ma; logic [31:0] md;
    logic en; logic we; logic [31:0] sa;
    logic iry; logic [31:0] ird; logic mry; logic [31:0] mrd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [64];
  vec_t vq[$];
  imem_dmem_arbiter_if b ();
  imem_dmem_arbiter_if b1 ();
  imem_dmem_arbiter #(.WAIT_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(b));
  imem_dmem_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  // SRAM model: combinational read, write on the rising edge
  always @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[4] <= E;
      mem[8] <= A1;
      mem[9] <= A2;
      mem[12] <= A3;
    end else if (b.sram_en && b.sram_we) mem[b.sram_addr[7:2]] <= b.sram_wdata;
  assign b.sram_rdata = mem[b.sram_addr[7:2]];
  assign b1.sram_rdata = mem[b1.sram_addr[7:2]];
  function automatic vec_t mk(logic ir, logic [31:0] ia, logic fl, logic mr, logic mw,
                              logic [31:0] ma, logic [31:0] md, logic en, logic we,
                              logic [31:0] sa, logic iry, logic [31:0] ird, logic mry,
                              logic [31:0] mrd);
    return {ir, ia, fl, mr, mw, ma, md, en, we, sa, iry, ird, mry, mrd};
  endfunction
  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(logic ir, logic [31:0] ia, logic fl, logic mr, logic mw,
                       logic [31:0] ma, logic [31:0] md);
    b.if_req = ir; b.if_addr = ia; b.if_flush = fl;
    b.mem_req = mr; b.mem_we = mw; b.mem_addr = ma; b.mem_wdata = md;
  endtask
  function automatic logic [101:0] outs();
    return {b.sram_en, b.sram_we, b.sram_addr, b.if_ready, b.if_rdata, b.mem_ready,
            b.mem_rdata, b.freeze_if, b.stall_pipe};
  endfunction
  initial begin
    vec_t v;
    drive(0, 0, 0, 0, 0, 0, 0);
    b1.if_req = 0; b1.if_addr = 0; b1.if_flush = 0;
    b1.mem_req = 0; b1.mem_we = 0; b1.mem_addr = 0; b1.mem_wdata = 0;
    // single fetch of 0x10
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 0,0,0,     0,0,0,0));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 1,0,'h10,  0,0,0,0));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 1,0,'h10,  0,0,0,0));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 0,0,0,     1,E,0,0));
    // write DEADBEEF to 0x40, then read it back
    vq.push_back(mk(0,0,0,    0,0,0,0, 0,0,0,     0,E,0,0));
    vq.push_back(mk(0,0,0,    1,1,'h40,D, 0,0,0,  0,E,0,0));
    vq.push_back(mk(0,0,0,    1,1,'h40,D, 1,1,'h40, 0,E,0,0));
    vq.push_back(mk(0,0,0,    1,1,'h40,D, 1,1,'h40, 0,E,0,0));
    vq.push_back(mk(0,0,0,    1,1,'h40,D, 0,0,0,  0,E,1,0));
    vq.push_back(mk(0,0,0,    1,0,'h40,0, 0,0,0,  0,E,0,0));
    vq.push_back(mk(0,0,0,    1,0,'h40,0, 1,0,'h40, 0,E,0,0));
    vq.push_back(mk(0,0,0,    1,0,'h40,0, 1,0,'h40, 0,E,0,0));
    vq.push_back(mk(0,0,0,    1,0,'h40,0, 0,0,0,  0,E,1,D));
    // both requesting with last grant = data: fetch, data, fetch
    vq.push_back(mk(1,'h20,0, 1,0,'h30,0, 0,0,0,    0,E,0,D));
    vq.push_back(mk(1,'h20,0, 1,0,'h30,0, 1,0,'h20, 0,E,0,D));
    vq.push_back(mk(1,'h20,0, 1,0,'h30,0, 1,0,'h20, 0,E,0,D));
    vq.push_back(mk(1,'h20,0, 1,0,'h30,0, 0,0,0,    1,A1,0,D));
    vq.push_back(mk(1,'h24,0, 1,0,'h30,0, 0,0,0,    0,A1,0,D));
    vq.push_back(mk(1,'h24,0, 1,0,'h30,0, 1,0,'h30, 0,A1,0,D));
    vq.push_back(mk(1,'h24,0, 1,0,'h30,0, 1,0,'h30, 0,A1,0,D));
    vq.push_back(mk(1,'h24,0, 1,0,'h30,0, 0,0,0,    0,A1,1,A3));
    vq.push_back(mk(1,'h24,0, 1,0,'h30,0, 0,0,0,    0,A1,0,A3));
    vq.push_back(mk(1,'h24,0, 1,0,'h30,0, 1,0,'h24, 0,A1,0,A3));
    vq.push_back(mk(1,'h24,0, 1,0,'h30,0, 1,0,'h24, 0,A1,0,A3));
    vq.push_back(mk(1,'h24,0, 1,0,'h30,0, 0,0,0,    1,A2,0,A3));
    // flush in the first ACC cycle of a fetch to 0x20, refetch from 0x10
    vq.push_back(mk(1,'h20,0, 0,0,0,0, 0,0,0,     0,A2,0,A3));
    vq.push_back(mk(1,'h10,1, 0,0,0,0, 1,0,'h20,  0,A2,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 1,0,'h20,  0,A2,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 0,0,0,     0,A2,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 0,0,0,     0,A2,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 1,0,'h10,  0,A2,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 1,0,'h10,  0,A2,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 0,0,0,     1,E,0,A3));
    // flush while idle holds off the fetch by one cycle
    vq.push_back(mk(1,'h10,1, 0,0,0,0, 0,0,0,     0,E,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 0,0,0,     0,E,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 1,0,'h10,  0,E,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 1,0,'h10,  0,E,0,A3));
    vq.push_back(mk(1,'h10,0, 0,0,0,0, 0,0,0,     1,E,0,A3));
    // flush has no effect on a data read
    vq.push_back(mk(0,0,1,    1,0,'h20,0, 0,0,0,    0,E,0,A3));
    vq.push_back(mk(0,0,1,    1,0,'h20,0, 1,0,'h20, 0,E,0,A3));
    vq.push_back(mk(0,0,0,    1,0,'h20,0, 1,0,'h20, 0,E,0,A3));
    vq.push_back(mk(0,0,0,    1,0,'h20,0, 0,0,0,    0,E,1,A1));
    vq.push_back(mk(0,0,0,    0,0,0,0,    0,0,0,    0,E,0,A1));
    #12;
    chk("reset_state", 128'(outs()), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    foreach (vq[k]) begin
      v = vq[k];
      drive(v.ir, v.ia, v.fl, v.mr, v.mw, v.ma, v.md);
      #1;
      chk($sformatf("vec%0d", k), 128'(outs()),
          128'({v.en, v.we, v.sa, v.iry, v.ird, v.mry, v.mrd, v.ir & ~v.iry, v.mr & ~v.mry}));
      @(negedge clk);
    end
    // asynchronous reset in the second ACC cycle of a write
    drive(0, 0, 0, 1, 1, 'h44, 32'hCAFEF00D);
    #1 chk("wr_idle_stall", 128'(b.stall_pipe), 128'(1));
    @(negedge clk);
    #1 chk("wr_acc1", 128'({b.sram_en, b.sram_we, b.sram_addr}), 128'({2'b11, 32'h44}));
    @(negedge clk);
    #1 chk("wr_acc2", 128'({b.sram_en, b.sram_we}), 128'(2'b11));
    #2 rst = 1'b0;
    #1 chk("async_rst", 128'({b.sram_en, b.sram_we, b.if_ready, b.mem_ready, b.if_rdata, b.mem_rdata}),
           128'(0));
    @(negedge clk);
    rst = 1'b1;
    drive(1, 'h10, 0, 1, 0, 'h40, 0);
    #1 chk("post_rst_idle", 128'({b.sram_en, b.mem_ready, b.if_ready}), 128'(0));
    @(negedge clk);
    #1 chk("post_rst_if_first", 128'({b.sram_en, b.sram_we, b.sram_addr}), 128'({2'b10, 32'h10}));
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    // WAIT_CYCLES=1: grant, ACC, RESP, then regrant every 3 cycles
    b1.if_req = 1'b1;
    b1.if_addr = 'h10;
    for (int k = 0; k < 6; k++) begin
      logic [5:0] en_pat, rdy_pat;
      en_pat = 6'b010010;
      rdy_pat = 6'b001001;
      #1 chk($sformatf("w1_cyc%0d", k), 128'({b1.sram_en, b1.if_ready, b1.mem_ready}),
             128'({en_pat[5-k], rdy_pat[5-k], 1'b0}));
      if (rdy_pat[5-k]) chk($sformatf("w1_data%0d", k), 128'(b1.if_rdata), 128'(E));
      @(negedge clk);
    end
    b1.if_req = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
